// File: rtl/ethernet_frame_dropper_pkg.sv
// Shared definitions for the multi-queue Ethernet frame dropper: FSM encoding,
// default frame limit and a constant-evaluable clog2 helper.
package ethernet_frame_dropper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        DROP    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_FRAME_BEATS = 1522;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter; a clear wins over a simultaneous increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register updates from values sampled before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ethernet_frame_dropper_multi.sv
// Whole-frame congestion dropper in front of a bank of per-queue FIFOs, with
// oversize-frame truncation and saturating pass/drop/truncate statistics.
module ethernet_frame_dropper_multi
    import ethernet_frame_dropper_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int C_NUM_QUEUES       = 4,
    parameter int C_TDEST_WIDTH      = 2,
    parameter int MAX_FRAME_BEATS    = DEFAULT_MAX_FRAME_BEATS,
    parameter int COUNTER_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drop_enable,
    input  logic [C_NUM_QUEUES-1:0]       fifo_is_almost_full,
    input  logic                          count_clear,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [C_TDEST_WIDTH-1:0]      s_axis_tdest,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [C_TDEST_WIDTH-1:0]      m_axis_tdest,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [COUNTER_WIDTH-1:0]      passed_count,
    output logic [COUNTER_WIDTH-1:0]      dropped_count,
    output logic [COUNTER_WIDTH-1:0]      truncated_count
);

    localparam int BEAT_W_RAW = clog2(MAX_FRAME_BEATS + 1);
    localparam int BEAT_W     = (BEAT_W_RAW < 1) ? 1 : BEAT_W_RAW;
    localparam int NUM_DESTS  = 2 ** C_TDEST_WIDTH;
    localparam bit TRUNC_EN   = (MAX_FRAME_BEATS > 0);
    localparam logic [BEAT_W-1:0] TRUNC_AT =
        TRUNC_EN ? BEAT_W'(MAX_FRAME_BEATS - 1) : '0;
    localparam logic [C_TDEST_WIDTH:0] NUM_Q = (C_TDEST_WIDTH + 1)'(C_NUM_QUEUES);

    state_t                   state, state_next;
    logic [BEAT_W-1:0]        beat_cnt, beat_cnt_next;
    logic [C_TDEST_WIDTH-1:0] dest_q, dest_next;
    logic [NUM_DESTS-1:0]     full_pad;
    logic                     dest_valid;
    logic                     drop_now;
    logic                     handshake;
    logic                     trunc_beat;
    logic                     inc_pass, inc_drop, inc_trunc;

    // Data and byte enables pass straight through; only the valid/ready/last
    // qualifiers depend on the frame decision.
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tdest = dest_q;
    assign handshake    = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            dest_q   <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            dest_q   <= dest_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        full_pad                   = '0;
        full_pad[C_NUM_QUEUES-1:0] = fifo_is_almost_full;
        dest_valid                 = {1'b0, s_axis_tdest} < NUM_Q;
        drop_now      = (drop_enable && full_pad[s_axis_tdest]) || !dest_valid;
        state_next    = state;
        beat_cnt_next = beat_cnt;
        dest_next     = dest_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        trunc_beat    = 1'b0;
        inc_pass      = 1'b0;
        inc_drop      = 1'b0;
        inc_trunc     = 1'b0;

        case (state)
            IDLE: begin
                // Decide once per frame without consuming a beat, so the
                // egress valid can never be withdrawn mid-frame.
                if (s_axis_tvalid) begin
                    dest_next  = s_axis_tdest;
                    state_next = drop_now ? DROP : PASS;
                end
            end
            PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                trunc_beat    = TRUNC_EN && (beat_cnt == TRUNC_AT) && !s_axis_tlast;
                m_axis_tlast  = s_axis_tlast || trunc_beat;
                m_axis_tuser  = trunc_beat;
                if (handshake) begin
                    beat_cnt_next = beat_cnt + BEAT_W'(1);
                    if (s_axis_tlast) begin
                        inc_pass      = 1'b1;
                        beat_cnt_next = '0;
                        state_next    = IDLE;
                    end else if (trunc_beat) begin
                        inc_trunc     = 1'b1;
                        beat_cnt_next = '0;
                        state_next    = DISCARD;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (handshake && s_axis_tlast) begin
                    inc_drop   = 1'b1;
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                s_axis_tready = 1'b1;
                if (handshake && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_passed (
        .clk   (clk),
        .rst   (rst),
        .clear (count_clear),
        .inc   (inc_pass),
        .count (passed_count)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_dropped (
        .clk   (clk),
        .rst   (rst),
        .clear (count_clear),
        .inc   (inc_drop),
        .count (dropped_count)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_truncated (
        .clk   (clk),
        .rst   (rst),
        .clear (count_clear),
        .inc   (inc_trunc),
        .count (truncated_count)
    );

endmodule

// File: tb/tb_ethernet_frame_dropper_multi.sv
// Directed bench: a driver pushes expected egress beats into a scoreboard queue,
// a negedge monitor pops and compares them; counters are checked per scenario.
module tb_ethernet_frame_dropper_multi;

    localparam int DW   = 8;
    localparam int KW   = 1;
    localparam int NQ   = 4;
    localparam int TW   = 2;
    localparam int MAXB = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          drop_enable;
    logic [NQ-1:0] almost_full;
    logic          count_clear;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [TW-1:0] s_tdest;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [TW-1:0] m_tdest;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic [31:0]   passed, dropped, truncated;

    logic          sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_m_tuser;
    logic [DW-1:0] sat_m_tdata;
    logic [KW-1:0] sat_m_tkeep;
    logic [TW-1:0] sat_m_tdest;
    logic [1:0]    sat_passed, sat_dropped, sat_truncated;

    int  n_total = 0;
    int  n_bad   = 0;
    bit  ready_mode = 1'b0;
    bit  stall_prev = 1'b0;
    logic [12:0] sb[$];

    always #5 clk = ~clk;

    ethernet_frame_dropper_multi #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_AXIS_TKEEP_WIDTH (KW),
        .C_NUM_QUEUES       (NQ),
        .C_TDEST_WIDTH      (TW),
        .MAX_FRAME_BEATS    (MAXB),
        .COUNTER_WIDTH      (32)
    ) dut (
        .clk (clk), .rst (rst), .drop_enable (drop_enable),
        .fifo_is_almost_full (almost_full), .count_clear (count_clear),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tdest (s_tdest),
        .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready), .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tdest (m_tdest),
        .m_axis_tvalid (m_tvalid), .m_axis_tready (m_tready), .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser), .passed_count (passed), .dropped_count (dropped),
        .truncated_count (truncated)
    );

    // Three-queue, 2-bit-counter instance: tdest=3 is invalid here and its
    // dropped counter saturates quickly.
    ethernet_frame_dropper_multi #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_AXIS_TKEEP_WIDTH (KW),
        .C_NUM_QUEUES       (3),
        .C_TDEST_WIDTH      (TW),
        .MAX_FRAME_BEATS    (MAXB),
        .COUNTER_WIDTH      (2)
    ) dut_sat (
        .clk (clk), .rst (rst), .drop_enable (drop_enable),
        .fifo_is_almost_full (almost_full[2:0]), .count_clear (count_clear),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tdest (s_tdest),
        .s_axis_tvalid (s_tvalid), .s_axis_tready (sat_s_tready), .s_axis_tlast (s_tlast),
        .m_axis_tdata (sat_m_tdata), .m_axis_tkeep (sat_m_tkeep), .m_axis_tdest (sat_m_tdest),
        .m_axis_tvalid (sat_m_tvalid), .m_axis_tready (m_tready), .m_axis_tlast (sat_m_tlast),
        .m_axis_tuser (sat_m_tuser), .passed_count (sat_passed), .dropped_count (sat_dropped),
        .truncated_count (sat_truncated)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Egress monitor: every accepted beat must match the head of the scoreboard,
    // and a stalled valid must still be asserted on the following cycle.
    always @(negedge clk) begin
        if (stall_prev) check("no_retract", m_tvalid, 1'b1);
        stall_prev <= m_tvalid && !m_tready;
        if (m_tvalid && m_tready) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0)
                check("beat", {m_tdest, m_tdata, m_tkeep, m_tlast, m_tuser}, sb.pop_front());
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = ready_mode ? ~m_tready : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [1:0] dest, input int nbeats, input logic [7:0] seed,
                              input bit pass, input int af_at, input int rst_at,
                              input bit clr_last, output int first_wait);
        bit cut;
        bit trunc_here;
        int waits;
        cut        = 1'b0;
        first_wait = -1;
        for (int i = 0; i < nbeats; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = seed + 8'(i);
            s_tkeep  = ~1'(i);
            s_tlast  = (i == nbeats - 1);
            s_tdest  = dest;
            if (i == af_at) almost_full = 4'b0100;
            if (i == rst_at) rst = 1'b1;
            if (clr_last && s_tlast) count_clear = 1'b1;
            if (pass && !cut) begin
                trunc_here = (i == MAXB - 1) && !s_tlast;
                sb.push_back({dest, s_tdata, s_tkeep, s_tlast | trunc_here, trunc_here});
                cut = trunc_here;
            end
            waits = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                waits++;
                if (waits > 40) begin
                    check("handshake_timeout", waits, 0);
                    break;
                end
            end
            if (i == 0) first_wait = waits;
            @(posedge clk);
            #1;
            rst         = 1'b0;
            count_clear = 1'b0;
            if (i == rst_at) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic clear_counters();
        count_clear = 1'b1;
        @(posedge clk);
        #1;
        count_clear = 1'b0;
    endtask

    initial begin
        int fw;
        rst = 1'b1; drop_enable = 1'b1; almost_full = '0; count_clear = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tdest = '0; s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 1'b0);
        check("rst_m_tdest", m_tdest, 2'd0);
        check("rst_passed", passed, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back 60-beat frames to queue 2, one bubble each
        for (int f = 0; f < 3; f++) begin
            send_frame(2'd2, 60, 8'(8'h10 * f), 1'b1, -1, -1, 1'b0, fw);
            check("t1_bubble", fw, 1);
        end
        check("t1_passed", passed, 32'd3);
        check("t1_dropped", dropped, 32'd0);
        clear_counters();

        // Congestion on the selected queue only
        almost_full = 4'b0100;
        send_frame(2'd2, 60, 8'h40, 1'b0, -1, -1, 1'b0, fw);
        check("t2_drop_bubble", fw, 1);
        check("t2_dropped", dropped, 32'd1);
        check("t2_passed0", passed, 32'd0);
        send_frame(2'd1, 60, 8'h80, 1'b1, -1, -1, 1'b0, fw);
        check("t2_passed", passed, 32'd1);
        check("t2_dropped_hold", dropped, 32'd1);
        almost_full = '0;
        clear_counters();

        // Mid-frame congestion and a toggling egress ready; dropping disabled
        ready_mode = 1'b1;
        send_frame(2'd2, 60, 8'h20, 1'b1, 10, -1, 1'b0, fw);
        almost_full = 4'hF;
        drop_enable = 1'b0;
        send_frame(2'd0, 20, 8'hA0, 1'b1, -1, -1, 1'b0, fw);
        check("t3_passed", passed, 32'd2);
        check("t3_dropped", dropped, 32'd0);
        ready_mode  = 1'b0;
        almost_full = '0;
        drop_enable = 1'b1;
        clear_counters();

        // Oversize frame is cut at MAXB beats; exactly MAXB beats is not
        send_frame(2'd1, 100, 8'h05, 1'b1, -1, -1, 1'b0, fw);
        check("t4_truncated", truncated, 32'd1);
        check("t4_passed0", passed, 32'd0);
        check("t4_dropped0", dropped, 32'd0);
        send_frame(2'd1, MAXB, 8'h33, 1'b1, -1, -1, 1'b0, fw);
        check("t4_passed", passed, 32'd1);
        check("t4_truncated_hold", truncated, 32'd1);
        clear_counters();

        // Invalid tdest on the 3-queue instance: saturation, then clear vs increment
        for (int f = 0; f < 5; f++)
            send_frame(2'd3, 3, 8'(8'hC0 + 8'(4 * f)), 1'b1, -1, -1, 1'b0, fw);
        check("t5_sat_dropped", sat_dropped, 2'd3);
        check("t5_passed", passed, 32'd5);
        send_frame(2'd3, 3, 8'hE0, 1'b1, -1, -1, 1'b1, fw);
        check("t5_sat_cleared", sat_dropped, 2'd0);
        check("t5_passed_cleared", passed, 32'd0);

        // Single-beat frame, then reset in the middle of a passing frame
        send_frame(2'd2, 1, 8'h55, 1'b1, -1, -1, 1'b0, fw);
        check("t6_single_passed", passed, 32'd1);
        send_frame(2'd2, 60, 8'h60, 1'b1, -1, 19, 1'b0, fw);
        @(negedge clk);
        check("t6_rst_s_tready", s_tready, 1'b0);
        check("t6_rst_m_tvalid", m_tvalid, 1'b0);
        check("t6_rst_m_tlast", m_tlast, 1'b0);
        check("t6_rst_m_tdest", m_tdest, 2'd0);
        check("t6_rst_passed", passed, 32'd0);
        @(posedge clk);
        #1;
        send_frame(2'd2, 40, 8'h60 + 8'd20, 1'b1, -1, -1, 1'b0, fw);
        check("t6_bubble", fw, 1);
        check("t6_passed", passed, 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ethernet_frame_dropper_multi.md
Name: ethernet_frame_dropper_multi

Overview:
Next-generation frame dropper for the CBS/TSN datapath. It sits between the ingress AXI4-Stream and a bank of per-queue FIFOs. It drops whole Ethernet frames when the queue selected by s_axis_tdest is almost full. It adds width-generic tkeep, multi-queue selection, oversize-frame truncation with an error flag, and saturating statistics counters.

Parameters:
C_AXIS_TDATA_WIDTH, 8, data width in bits (multiple of 8)
C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, tkeep width
C_NUM_QUEUES, 4, number of destination FIFOs (1..16)
C_TDEST_WIDTH, 2, tdest width; must satisfy 2**C_TDEST_WIDTH >= C_NUM_QUEUES
MAX_FRAME_BEATS, 1522, beat limit per frame; 0 disables truncation
COUNTER_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
drop_enable  in  1  1 = congestion dropping allowed
fifo_is_almost_full  in  C_NUM_QUEUES  per-queue almost_full from rear FIFOs
count_clear  in  1  synchronous clear of all counters
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  ingress data
s_axis_tkeep  in  C_AXIS_TKEEP_WIDTH  ingress byte enables
s_axis_tdest  in  C_TDEST_WIDTH  queue select; sampled on the first beat of the frame
s_axis_tvalid  in  1  ingress valid
s_axis_tready  out  1  ingress ready
s_axis_tlast  in  1  ingress end of frame
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  egress data
m_axis_tkeep  out  C_AXIS_TKEEP_WIDTH  egress byte enables
m_axis_tdest  out  C_TDEST_WIDTH  latched queue select
m_axis_tvalid  out  1  egress valid
m_axis_tready  in  1  egress ready
m_axis_tlast  out  1  egress end of frame (forced on truncation)
m_axis_tuser  out  1  1 on the forced last beat of a truncated frame
passed_count  out  COUNTER_WIDTH  frames fully forwarded
dropped_count  out  COUNTER_WIDTH  frames dropped for congestion or invalid tdest
truncated_count  out  COUNTER_WIDTH  frames cut at MAX_FRAME_BEATS

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, beat counter=0, all counters=0, latched tdest=0. Outputs s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0.
- FSM states: IDLE, PASS, DROP, DISCARD.
- IDLE: s_axis_tready=0, m_axis_tvalid=0. If s_axis_tvalid=1, evaluate at this posedge:
  - drop = (drop_enable && fifo_is_almost_full[tdest]) || (tdest >= C_NUM_QUEUES).
  - Latch tdest; go to DROP if drop, else PASS. No beat is consumed.
  - This gives exactly 1 bubble cycle per frame and freezes the decision, so m_axis_tvalid never retracts.
- PASS: m_axis_{tdata,tkeep,tvalid} = s_axis_*; m_axis_tdest = latched value; s_axis_tready = m_axis_tready; zero latency, combinational.
  - On each handshake the beat counter increments.
  - tlast handshake: passed_count++, beat counter cleared, go to IDLE.
  - If MAX_FRAME_BEATS>0, the beat counter equals MAX_FRAME_BEATS-1 and s_axis_tlast=0 on the handshake beat:
    - force m_axis_tlast=1 and m_axis_tuser=1 on that beat;
    - truncated_count++; go to DISCARD.
- DROP: s_axis_tready=1, m_axis_tvalid=0. Consume until tlast handshake, then dropped_count++ and go to IDLE.
- DISCARD: same as DROP, but no counter increments on exit (the frame is already counted as truncated).
- Changes to fifo_is_almost_full or drop_enable mid-frame have no effect; the decision is per-frame only.
- A single-beat frame (tlast on first beat) goes IDLE→PASS/DROP→IDLE normally. With MAX_FRAME_BEATS=1, only frames longer than 1 beat are truncated.
- Counters saturate at all-ones. count_clear has priority over a simultaneous increment.
- Reset mid-frame returns to IDLE. Remaining beats of that frame are treated as a new frame; downstream must tolerate this.
- Beat counter width: clog2(MAX_FRAME_BEATS+1), minimum 1.

Decomposition:
- Package ethernet_frame_dropper_pkg holds:
  - state encoding localparams (IDLE=2'd0, PASS=2'd1, DROP=2'd2, DISCARD=2'd3);
  - a clog2 function;
  - the default MAX_FRAME_BEATS.
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst, clear, inc, count), instantiated three times.

Test Plan:
Common config: DATA_WIDTH=8, C_NUM_QUEUES=4, MAX_FRAME_BEATS=64.
1. drop_enable=1, all almost_full=0, three 60-beat frames to tdest=2, m_axis_tready=1 → all bytes forwarded, m_axis_tdest=2, 1 idle cycle between frames, passed_count=3.
2. fifo_is_almost_full=4'b0100 during the IDLE decision cycle, frame to tdest=2 → no m_axis_tvalid, 60 beats consumed, dropped_count=1. Same frame to tdest=1 → forwarded, passed_count=1.
3. almost_full[2] rises on beat 10 of a passing frame; m_axis_tready toggles 1010… → full frame forwarded, no tvalid retraction. drop_enable=0 with almost_full=4'hF → frame passes.
4. 100-beat frame → 64 beats out, 64th beat has tlast=1 and tuser=1, remaining 36 beats consumed silently, truncated_count=1, passed_count=0. 64-beat frame → passes untruncated.
5. COUNTER_WIDTH=2: 5 dropped frames → dropped_count=3 (saturated). count_clear asserted on the cycle a tlast completes → counter reads 0 next cycle.
6. rst pulsed on beat 20 of a 60-beat pass frame → outputs at reset values next cycle, then beats 21-60 handled as a new 40-beat frame (1 bubble, then forwarded), passed_count=1.
